mem_port_arbiter: RTL and testbench
===================================

Name: mem_port_arbiter

Overview:
- Shares one port of the main-memory dual-port block RAM between two requesters: requester 0 is the CPU data side and requester 1 is the DMA/IO side.
- Arbitration is round-robin with a bounded burst, so a requester holding req keeps consecutive cycles only up to MAX_BURST while the other is waiting.
- The block drives the RAM port's we/addr/din and returns the RAM's 1-cycle-latency read data with a per-requester valid strobe.
- It sits between the requesters and the RAM port; the other RAM port is untouched.

Parameters:
- DATA, 18, data width; matches RAM word.
- ADDR, 14, address width; matches RAM depth.
- MAX_BURST, 4, maximum consecutive grants to one requester while the other is requesting; legal range 1..7.
- CW, 3, burst counter width; must satisfy 2^CW > MAX_BURST.

Ports:
- clka  in  1  clock, shared with the RAM.
- reset  in  1  synchronous, active-high reset.
- req0  in  1  requester 0 access request.
- we0  in  1  requester 0 write (1) / read (0).
- addr0  in  ADDR  requester 0 address.
- wdata0  in  DATA  requester 0 write data.
- gnt0  out  1  requester 0 access performed this cycle (combinational).
- rvalid0  out  1  rdata valid for requester 0's read granted last cycle.
- rdata0  out  DATA  read data for requester 0.
- req1, we1, addr1, wdata1, gnt1, rvalid1, rdata1: identical set for requester 1.
- mem_we  out  1  RAM port write enable.
- mem_addr  out  ADDR  RAM port address.
- mem_din  out  DATA  RAM port write data.
- mem_dout  in  DATA  RAM port registered read data.

Behaviour:
- Registered state:
  - owner FSM: IDLE, OWN0, OWN1.
  - cnt[CW-1:0]: consecutive grants to the current owner.
  - last: last granted requester.
  - rv0, rv1: read-valid pipeline bits.
- Reset values: owner=IDLE, cnt=0, last=1 (requester 0 wins the first tie), rv0=rv1=0. Hence rvalid0=rvalid1=0 and gnt0=gnt1=0 unless a req is asserted.
- Grant decision, combinational each cycle, at most one grant:
  - OWNx: keep x if req_x && (cnt < MAX_BURST || !req_other). Otherwise grant the other requester if req_other. Otherwise no grant.
  - IDLE: if only one requester is asserting, grant it. If both are asserting, grant the requester != last. If neither, no grant.
- Port mux, combinational:
  - On a grant, mem_addr/mem_din/mem_we take the granted requester's addr/wdata/we.
  - With no grant: mem_we=0, mem_addr=0, mem_din=0.
  - A write is never issued without a grant.
- Next state on each clock edge:
  - Grant to x with x == current owner: cnt <= min(cnt+1, MAX_BURST).
  - Grant to x with x != current owner: owner <= OWNx, cnt <= 1.
  - Any grant to x: last <= x.
  - No grant: owner <= IDLE, cnt <= 0, last unchanged.
- Read return:
  - rv_x <= gnt_x && !we_x, so rvalid_x is asserted exactly 1 cycle after a granted read.
  - rdata0 = rdata1 = mem_dout, driven combinationally; only meaningful while the matching rvalid is high.
  - A granted write produces no rvalid.
- Back-to-back reads are fully pipelined at 1 access per cycle. The rvalid of a read granted at cycle t coincides with a grant at t+1.
- Handshake: a requester holds req/we/addr/wdata stable until it sees gnt high in the same cycle. A req dropped before being granted is simply not serviced; there is no queueing.
- Both requesters continuously requesting with MAX_BURST=N: N grants to one, then N to the other, alternating indefinitely with no idle cycles.
- MAX_BURST=1: strict alternation whenever both are requesting.
- A lone requester is granted every cycle indefinitely. cnt saturates at MAX_BURST and never wraps.
- Same-address read by one requester and write by the other in the same cycle: impossible, because only one access is granted per cycle. Ordering is grant order. A read granted 1 cycle after a write to the same address returns the new data (the RAM writes on the edge, and the subsequent read samples the updated array).
- reset asserted mid-burst or with a read in flight: all state returns to reset values at the next edge. The pending rvalid is dropped (rvalid=0 the cycle after reset). While reset is high, the grant logic still evaluates from reset state, but the RAM write is suppressed: mem_we=0 and gnt0=gnt1=0 while reset=1.

Test Plan:
- Reset, then req0=1 we0=0 addr0=0x0010 alone for 3 cycles -> gnt0=1 each cycle; rvalid0=1 on cycles 2-4; rdata0=contents of 0x0010.
- Both req held with reads, MAX_BURST=4, reset first -> gnt pattern 0,0,0,0,1,1,1,1,0,... with exactly one gnt per cycle; rvalid follows each grant by 1 cycle to the correct requester.
- req1 writes 0x2AAAA to 0x0123 (granted at t); req0 reads 0x0123 granted at t+1 -> rvalid0 at t+2 with rdata0=0x2AAAA; rvalid1 never asserted.
- req0 alone for 10 cycles, then req1 rises -> req0 keeps the grant (cnt saturated at 4) through the cycle req1 rises? No: grant switches to 1 in that same cycle, since cnt=MAX_BURST and req1=1 -> gnt1=1; cnt=1 the next cycle.
- Read granted, then reset asserted the next cycle -> rvalid0=0 after the reset edge; gnt0=gnt1=0 and mem_we=0 during reset; after deassert with both requesting, requester 0 wins.
- MAX_BURST=1, both writing continuously -> strict 0,1,0,1 alternation; RAM contents match the per-requester write sequence.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// Two-requester round-robin arbiter with bounded bursts in front of one
// synchronous RAM port; returns 1-cycle read data with per-requester valids.
module mem_port_arbiter #(
  parameter int unsigned DATA      = 18,
  parameter int unsigned ADDR      = 14,
  parameter int unsigned MAX_BURST = 4,
  parameter int unsigned CW        = 3
) (
  input  logic            clka,
  input  logic            reset,
  input  logic            req0,
  input  logic            we0,
  input  logic [ADDR-1:0] addr0,
  input  logic [DATA-1:0] wdata0,
  output logic            gnt0,
  output logic            rvalid0,
  output logic [DATA-1:0] rdata0,
  input  logic            req1,
  input  logic            we1,
  input  logic [ADDR-1:0] addr1,
  input  logic [DATA-1:0] wdata1,
  output logic            gnt1,
  output logic            rvalid1,
  output logic [DATA-1:0] rdata1,
  output logic            mem_we,
  output logic [ADDR-1:0] mem_addr,
  output logic [DATA-1:0] mem_din,
  input  logic [DATA-1:0] mem_dout
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OWN0 = 2'd1,
    OWN1 = 2'd2
  } state_e;

  localparam logic [CW-1:0] MAX_CNT = CW'(MAX_BURST);

  state_e          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            last_q, last_d;
  logic            rv0_q, rv0_d;
  logic            rv1_q, rv1_d;
  logic            pick0, pick1;
  logic            below_max;

  assign below_max = cnt_q < MAX_CNT;

  // Grant decision from the current owner, burst count and last winner
  always_comb begin
    pick0 = 1'b0;
    pick1 = 1'b0;
    case (state_q)
      OWN0: begin
        if (req0 && (below_max || !req1)) pick0 = 1'b1;
        else if (req1)                    pick1 = 1'b1;
      end
      OWN1: begin
        if (req1 && (below_max || !req0)) pick1 = 1'b1;
        else if (req0)                    pick0 = 1'b1;
      end
      default: begin
        if (req0 && req1) begin
          pick0 = last_q;
          pick1 = !last_q;
        end else begin
          pick0 = req0;
          pick1 = req1;
        end
      end
    endcase
  end

  // Grants are masked while reset is held so no RAM write can escape
  assign gnt0 = pick0 & ~reset;
  assign gnt1 = pick1 & ~reset;

  always_comb begin
    mem_we   = 1'b0;
    mem_addr = '0;
    mem_din  = '0;
    if (gnt0) begin
      mem_we   = we0;
      mem_addr = addr0;
      mem_din  = wdata0;
    end else if (gnt1) begin
      mem_we   = we1;
      mem_addr = addr1;
      mem_din  = wdata1;
    end
  end

  // Next-state: ownership, saturating burst count, tie-break history
  always_comb begin
    state_d = IDLE;
    cnt_d   = '0;
    last_d  = last_q;
    rv0_d   = gnt0 & ~we0;
    rv1_d   = gnt1 & ~we1;
    if (gnt0) begin
      last_d  = 1'b0;
      state_d = OWN0;
      if (state_q == OWN0) cnt_d = below_max ? cnt_q + CW'(1) : cnt_q;
      else                 cnt_d = CW'(1);
    end else if (gnt1) begin
      last_d  = 1'b1;
      state_d = OWN1;
      if (state_q == OWN1) cnt_d = below_max ? cnt_q + CW'(1) : cnt_q;
      else                 cnt_d = CW'(1);
    end
  end

  always_ff @(posedge clka) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      last_q  <= 1'b1;
      rv0_q   <= 1'b0;
      rv1_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      last_q  <= last_d;
      rv0_q   <= rv0_d;
      rv1_q   <= rv1_d;
    end
  end

  assign rvalid0 = rv0_q;
  assign rvalid1 = rv1_q;
  assign rdata0  = mem_dout;
  assign rdata1  = mem_dout;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: vector table plus read-return scoreboard on a
// MAX_BURST=4 instance, and a strict-alternation write sequence on MAX_BURST=1.
module tb_mem_port_arbiter;
  localparam int unsigned DATA = 18;
  localparam int unsigned ADDR = 14;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic            reset;
  logic            req0, we0, req1, we1;
  logic [ADDR-1:0] addr0, addr1;
  logic [DATA-1:0] wdata0, wdata1;

  logic            a_gnt0, a_gnt1, a_rv0, a_rv1, a_we;
  logic [DATA-1:0] a_rd0, a_rd1, a_din, a_dout;
  logic [ADDR-1:0] a_addr;
  logic            b_gnt0, b_gnt1, b_rv0, b_rv1, b_we;
  logic [DATA-1:0] b_rd0, b_rd1, b_din, b_dout;
  logic [ADDR-1:0] b_addr;

  logic            pl_en;
  logic [ADDR-1:0] pl_addr;
  logic [DATA-1:0] pl_data;

  logic [DATA-1:0] ram_a [0:2**ADDR-1];
  logic [DATA-1:0] ram_b [0:2**ADDR-1];

  always @(posedge clk) begin
    if (pl_en) ram_a[pl_addr] <= pl_data;
    else if (a_we) ram_a[a_addr] <= a_din;
    a_dout <= ram_a[a_addr];
  end

  always @(posedge clk) begin
    if (pl_en) ram_b[pl_addr] <= pl_data;
    else if (b_we) ram_b[b_addr] <= b_din;
    b_dout <= ram_b[b_addr];
  end

  mem_port_arbiter #(.DATA(DATA), .ADDR(ADDR), .MAX_BURST(4), .CW(3)) u_dut (
    .clka(clk), .reset(reset),
    .req0(req0), .we0(we0), .addr0(addr0), .wdata0(wdata0),
    .gnt0(a_gnt0), .rvalid0(a_rv0), .rdata0(a_rd0),
    .req1(req1), .we1(we1), .addr1(addr1), .wdata1(wdata1),
    .gnt1(a_gnt1), .rvalid1(a_rv1), .rdata1(a_rd1),
    .mem_we(a_we), .mem_addr(a_addr), .mem_din(a_din), .mem_dout(a_dout)
  );

  mem_port_arbiter #(.DATA(DATA), .ADDR(ADDR), .MAX_BURST(1), .CW(3)) u_dut1 (
    .clka(clk), .reset(reset),
    .req0(req0), .we0(we0), .addr0(addr0), .wdata0(wdata0),
    .gnt0(b_gnt0), .rvalid0(b_rv0), .rdata0(b_rd0),
    .req1(req1), .we1(we1), .addr1(addr1), .wdata1(wdata1),
    .gnt1(b_gnt1), .rvalid1(b_rv1), .rdata1(b_rd1),
    .mem_we(b_we), .mem_addr(b_addr), .mem_din(b_din), .mem_dout(b_dout)
  );

  typedef struct {
    logic            rst;
    logic            r0, w0;
    logic [ADDR-1:0] a0;
    logic [DATA-1:0] d0;
    logic            r1, w1;
    logic [ADDR-1:0] a1;
    logic [DATA-1:0] d1;
    logic            eg0, eg1;
  } vec_t;

  typedef struct {
    logic            who;
    logic [DATA-1:0] data;
  } rd_t;

  vec_t            vecs[$];
  rd_t             sb_q[$];
  logic [DATA-1:0] ref_mem [int];
  int              checks = 0;
  int              errors = 0;

  function automatic vec_t mk(input logic rst, input logic r0, input logic w0,
                              input logic [ADDR-1:0] a0, input logic [DATA-1:0] d0,
                              input logic r1, input logic w1,
                              input logic [ADDR-1:0] a1, input logic [DATA-1:0] d1,
                              input logic eg0, input logic eg1);
    vec_t v;
    v.rst = rst; v.r0 = r0; v.w0 = w0; v.a0 = a0; v.d0 = d0;
    v.r1 = r1; v.w1 = w1; v.a1 = a1; v.d1 = d1; v.eg0 = eg0; v.eg1 = eg1;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic preload(input logic [ADDR-1:0] a, input logic [DATA-1:0] d);
    @(negedge clk);
    pl_en = 1'b1; pl_addr = a; pl_data = d;
    ref_mem[int'(a)] = d;
    @(negedge clk);
    pl_en = 1'b0;
  endtask

  // One cycle on the MAX_BURST=4 instance: grants, port mux, read return
  task automatic run_vec(input vec_t v);
    logic            ew;
    logic [ADDR-1:0] ea;
    logic [DATA-1:0] ed;
    rd_t             r;
    @(negedge clk);
    reset = v.rst;
    req0 = v.r0; we0 = v.w0; addr0 = v.a0; wdata0 = v.d0;
    req1 = v.r1; we1 = v.w1; addr1 = v.a1; wdata1 = v.d1;
    #1;
    check("gnt0", 32'(a_gnt0), 32'(v.eg0));
    check("gnt1", 32'(a_gnt1), 32'(v.eg1));
    ew = (v.eg0 & v.w0) | (v.eg1 & v.w1);
    ea = v.eg0 ? v.a0 : (v.eg1 ? v.a1 : '0);
    ed = v.eg0 ? v.d0 : (v.eg1 ? v.d1 : '0);
    check("mem_we", 32'(a_we), 32'(ew));
    check("mem_addr", 32'(a_addr), 32'(ea));
    check("mem_din", 32'(a_din), 32'(ed));
    if (sb_q.size() > 0) begin
      r = sb_q.pop_front();
      check("rvalid0", 32'(a_rv0), 32'(!r.who));
      check("rvalid1", 32'(a_rv1), 32'(r.who));
      check("rdata", 32'(r.who ? a_rd1 : a_rd0), 32'(r.data));
    end else begin
      check("rvalid0_idle", 32'(a_rv0), 32'd0);
      check("rvalid1_idle", 32'(a_rv1), 32'd0);
    end
    if (v.rst) sb_q.delete();
    else if (v.eg0 && !v.w0) sb_q.push_back('{1'b0, ref_mem[int'(v.a0)]});
    else if (v.eg1 && !v.w1) sb_q.push_back('{1'b1, ref_mem[int'(v.a1)]});
    if (ew) ref_mem[int'(ea)] = ed;
  endtask

  initial begin
    int i0, i1;
    logic exp0;
    logic [DATA-1:0] d;

    reset = 1'b1; pl_en = 1'b0; pl_addr = '0; pl_data = '0;
    req0 = 0; we0 = 0; addr0 = '0; wdata0 = '0;
    req1 = 0; we1 = 0; addr1 = '0; wdata1 = '0;

    preload(14'h0010, 18'h0ABCD);
    preload(14'h0020, 18'h13579);
    preload(14'h0123, 18'h01111);
    preload(14'h0040, 18'h00777);

    // reset, including both requesters active (grants and writes masked)
    vecs.push_back(mk(1, 0,0,0,0, 0,0,0,0, 0,0));
    vecs.push_back(mk(1, 1,1,14'h10,18'h5, 1,1,14'h20,18'h6, 0,0));
    // lone read by requester 0
    for (int i = 0; i < 3; i++) vecs.push_back(mk(0, 1,0,14'h10,0, 0,0,0,0, 1,0));
    vecs.push_back(mk(0, 0,0,0,0, 0,0,0,0, 0,0));
    // both reading after reset: 0000 1111 00
    vecs.push_back(mk(1, 1,0,14'h10,0, 1,0,14'h20,0, 0,0));
    for (int i = 0; i < 10; i++)
      vecs.push_back(mk(0, 1,0,14'h10,0, 1,0,14'h20,0, (i < 4 || i >= 8), (i >= 4 && i < 8)));
    vecs.push_back(mk(0, 0,0,0,0, 0,0,0,0, 0,0));
    // write by 1 then read-after-write by 0
    vecs.push_back(mk(0, 0,0,0,0, 1,1,14'h123,18'h2AAAA, 0,1));
    vecs.push_back(mk(0, 1,0,14'h123,0, 0,0,0,0, 1,0));
    vecs.push_back(mk(0, 0,0,0,0, 0,0,0,0, 0,0));
    // requester 0 alone for 10 cycles, then requester 1 joins
    vecs.push_back(mk(0, 1,1,14'h40,18'h15555, 0,0,0,0, 1,0));
    for (int i = 0; i < 9; i++) vecs.push_back(mk(0, 1,0,14'h40,0, 0,0,0,0, 1,0));
    for (int i = 0; i < 5; i++)
      vecs.push_back(mk(0, 1,0,14'h40,0, 1,0,14'h20,0, (i >= 4), (i < 4)));
    vecs.push_back(mk(0, 0,0,0,0, 0,0,0,0, 0,0));
    // read in flight when reset hits; requester 0 wins afterwards
    vecs.push_back(mk(0, 0,0,0,0, 1,0,14'h20,0, 0,1));
    vecs.push_back(mk(1, 1,0,14'h10,0, 1,0,14'h20,0, 0,0));
    vecs.push_back(mk(0, 1,0,14'h10,0, 1,0,14'h20,0, 1,0));
    vecs.push_back(mk(0, 1,0,14'h10,0, 1,0,14'h20,0, 1,0));
    vecs.push_back(mk(0, 0,0,0,0, 0,0,0,0, 0,0));
    vecs.push_back(mk(0, 0,0,0,0, 0,0,0,0, 0,0));

    foreach (vecs[k]) run_vec(vecs[k]);

    // MAX_BURST=1 instance: both writing continuously must alternate 0,1,0,1
    @(negedge clk);
    reset = 1'b1; req0 = 0; req1 = 0; we0 = 0; we1 = 0;
    i0 = 0; i1 = 0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      reset = 1'b0;
      req0 = 1'b1; we0 = 1'b1; addr0 = 14'h200 + ADDR'(i0); wdata0 = 18'h01000 + DATA'(i0);
      req1 = 1'b1; we1 = 1'b1; addr1 = 14'h300 + ADDR'(i1); wdata1 = 18'h02000 + DATA'(i1 * 7);
      #1;
      exp0 = ((c % 2) == 0);
      check("mb1_gnt0", 32'(b_gnt0), 32'(exp0));
      check("mb1_gnt1", 32'(b_gnt1), 32'(!exp0));
      check("mb1_mem_we", 32'(b_we), 32'd1);
      if (exp0) i0++;
      else      i1++;
    end
    @(negedge clk);
    req0 = 0; req1 = 0; we0 = 0; we1 = 0;
    @(negedge clk);
    for (int k = 0; k < 4; k++) begin
      d = 18'h01000 + DATA'(k);
      check("mb1_ram0", 32'(ram_b[14'h200 + ADDR'(k)]), 32'(d));
      d = 18'h02000 + DATA'(k * 7);
      check("mb1_ram1", 32'(ram_b[14'h300 + ADDR'(k)]), 32'(d));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
